// File: rtl/instr_decode_queue_if.sv
// Handshake and decoded-head bundle between fetch, the decode queue and the control FSM.
// The queue attaches through the slave modport; the fetch/consume side attaches through master.
interface instr_decode_queue_if #(
    parameter int DEPTH     = 4,
    parameter int IMM_WIDTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          instruction;
    logic                 out_valid;
    logic                 out_ready;
    logic [5:0]           opcode;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           rd;
    logic [4:0]           shamt;
    logic [5:0]           funct;
    logic [15:0]          immediate;
    logic [IMM_WIDTH-1:0] imm_ext;
    logic [25:0]          address;
    logic                 is_rtype;
    logic                 is_jump;
    logic                 is_branch;
    logic                 is_load;
    logic                 is_store;
    logic                 is_illegal;
    logic [CW-1:0]        count;

    modport slave (
        input  in_valid, instruction, out_ready,
        output in_ready, out_valid, opcode, rs, rt, rd, shamt, funct, immediate,
               imm_ext, address, is_rtype, is_jump, is_branch, is_load, is_store,
               is_illegal, count
    );

    modport master (
        output in_valid, instruction, out_ready,
        input  in_ready, out_valid, opcode, rs, rt, rd, shamt, funct, immediate,
               imm_ext, address, is_rtype, is_jump, is_branch, is_load, is_store,
               is_illegal, count
    );
endinterface

// File: rtl/instr_decode_queue.sv
// DEPTH-entry instruction FIFO presenting its head entry as decoded MIPS fields and class flags.
// Latency: a word pushed into an empty queue is visible, decoded, right after the capturing edge.
// Backpressure: in_ready drops only when full; a pop in that cycle re-opens it on the next edge.
module instr_decode_queue #(
    parameter int DEPTH       = 4,
    parameter int IMM_WIDTH   = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    instr_decode_queue_if.slave     bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   in_ready, out_valid, push, pop;
    logic [INSTR_WIDTH-1:0] head;

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = bus.in_valid && in_ready;
    assign pop       = out_valid && bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth lets the pointers wrap by natural overflow.
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (!reset && !flush && push) begin
            mem_q[wr_ptr_q] <= bus.instruction;
        end
    end

    assign head = out_valid ? mem_q[rd_ptr_q] : '0;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.count     = count_q;
    assign bus.opcode    = head[31:26];
    assign bus.rs        = head[25:21];
    assign bus.rt        = head[20:16];
    assign bus.rd        = head[15:11];
    assign bus.shamt     = head[10:6];
    assign bus.funct     = head[5:0];
    assign bus.immediate = head[15:0];
    assign bus.address   = head[25:0];

    always_comb begin
        bus.is_rtype   = 1'b0;
        bus.is_jump    = 1'b0;
        bus.is_branch  = 1'b0;
        bus.is_load    = 1'b0;
        bus.is_store   = 1'b0;
        bus.is_illegal = 1'b0;
        bus.imm_ext    = IMM_WIDTH'($signed(head[15:0]));
        unique case (head[31:26])
            6'h00:                      bus.is_rtype  = 1'b1;
            6'h02, 6'h03:               bus.is_jump   = 1'b1;
            6'h04, 6'h05:               bus.is_branch = 1'b1;
            6'h23:                      bus.is_load   = 1'b1;
            6'h2B:                      bus.is_store  = 1'b1;
            6'h08, 6'h09, 6'h0A, 6'h0F: ;
            6'h0C, 6'h0D, 6'h0E:        bus.imm_ext   = IMM_WIDTH'(head[15:0]);
            default:                    bus.is_illegal = 1'b1;
        endcase
        // An empty queue reads as opcode 0, which must not look like an R-type.
        if (!out_valid) bus.is_rtype = 1'b0;
    end
endmodule

// File: tb/tb_instr_decode_queue.sv
// Directed and randomized stimulus against a word-queue scoreboard with a reference decoder.
module tb_instr_decode_queue;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;
    logic [31:0] sb [$];

    always #5 clk = ~clk;

    instr_decode_queue_if #(.DEPTH(DEPTH), .IMM_WIDTH(32)) bus ();

    instr_decode_queue #(.DEPTH(DEPTH), .IMM_WIDTH(32), .INSTR_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [111:0] obs, input logic [111:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    endtask

    function automatic logic [111:0] model_dec(input logic [31:0] w);
        logic [5:0]  op;
        logic [31:0] ie;
        logic [5:0]  fl;
        op = w[31:26];
        if (op == 6'h0C || op == 6'h0D || op == 6'h0E) ie = {16'h0000, w[15:0]};
        else                                           ie = {{16{w[15]}}, w[15:0]};
        case (op)
            6'h00:                      fl = 6'b100000;
            6'h02, 6'h03:               fl = 6'b010000;
            6'h04, 6'h05:               fl = 6'b001000;
            6'h23:                      fl = 6'b000100;
            6'h2B:                      fl = 6'b000010;
            6'h08, 6'h09, 6'h0A, 6'h0C,
            6'h0D, 6'h0E, 6'h0F:        fl = 6'b000000;
            default:                    fl = 6'b000001;
        endcase
        return {op, w[25:21], w[20:16], w[15:11], w[10:6], w[5:0], w[15:0], ie, w[25:0], fl};
    endfunction

    function automatic logic [111:0] dut_dec();
        return {bus.opcode, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct, bus.immediate,
                bus.imm_ext, bus.address, bus.is_rtype, bus.is_jump, bus.is_branch,
                bus.is_load, bus.is_store, bus.is_illegal};
    endfunction

    // One clock: drive, update scoreboard, check head before the edge and state after it.
    task automatic cycle(input logic v, input logic [31:0] w, input logic r,
                         input logic fl, input logic rs);
        logic do_push, do_pop;
        bus.in_valid    = v;
        bus.instruction = w;
        bus.out_ready   = r;
        flush           = fl;
        reset           = rs;
        if (rs || fl) begin
            sb.delete();
        end else begin
            do_push = v && (sb.size() < DEPTH);
            do_pop  = r && (sb.size() != 0);
            if (do_pop) begin
                chk("pop_head", dut_dec(), model_dec(sb[0]));
                void'(sb.pop_front());
            end
            if (do_push) sb.push_back(w);
        end
        @(posedge clk);
        #1;
        chk("count",     112'(bus.count),     112'(sb.size()));
        chk("out_valid", 112'(bus.out_valid), 112'(sb.size() != 0));
        chk("in_ready",  112'(bus.in_ready),  112'(sb.size() < DEPTH));
        if (sb.size() == 0) chk("idle_dec", dut_dec(), 112'(0));
        else                chk("head_now", dut_dec(), model_dec(sb[0]));
    endtask

    logic [5:0] ops [10] = '{6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0E, 6'h23, 6'h2B, 6'h3F};

    initial begin
        bus.in_valid    = 1'b0;
        bus.instruction = '0;
        bus.out_ready   = 1'b0;

        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h12345678, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

        // lw held at the head while the consumer stalls
        cycle(1'b1, 32'h8C820004, 1'b0, 1'b0, 1'b0);
        chk("lw_fields", 112'({bus.is_load, bus.rs, bus.rt, bus.imm_ext, bus.count}),
            112'({1'b1, 5'd4, 5'd2, 32'h00000004, 3'd1}));
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        chk("lw_hold", 112'({bus.is_load, bus.rs, bus.rt, bus.imm_ext}),
            112'({1'b1, 5'd4, 5'd2, 32'h00000004}));
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        cycle(1'b1, 32'h2002FFFF, 1'b0, 1'b0, 1'b0);
        chk("addi_sext", 112'(bus.imm_ext), 112'(32'hFFFFFFFF));
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h3402FFFF, 1'b0, 1'b0, 1'b0);
        chk("ori_zext", 112'(bus.imm_ext), 112'(32'h0000FFFF));
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h00851020, 1'b0, 1'b0, 1'b0);
        chk("add_rtype", 112'({bus.is_rtype, bus.rd, bus.funct, bus.shamt}),
            112'({1'b1, 5'd2, 6'h20, 5'd0}));
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // fill, refused fifth word, then streaming across pointer wrap
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'hA0000000 + 32'(i), 1'b0, 1'b0, 1'b0);
        chk("full", 112'({bus.count, bus.in_ready}), 112'({3'd4, 1'b0}));
        cycle(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'hB0000000 + 32'(i), 1'b1, 1'b0, 1'b0);
        while (sb.size() != 0) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // flush beats a simultaneous push and pop
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h21000000 + 32'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h8FFF0001, 1'b1, 1'b1, 1'b0);
        chk("flush_state", 112'({bus.count, bus.out_valid}), 112'({3'd0, 1'b0}));
        cycle(1'b1, 32'h2004000A, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        // reset beats a simultaneous push and pop
        for (int i = 0; i < 2; i++) cycle(1'b1, 32'hAC000000 + 32'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h8C000010, 1'b1, 1'b0, 1'b1);
        chk("reset_state", 112'({bus.count, bus.in_ready, bus.out_valid}), 112'({3'd0, 1'b1, 1'b0}));

        cycle(1'b1, 32'hFC000000, 1'b0, 1'b0, 1'b0);
        chk("illegal", 112'({bus.is_illegal, bus.is_rtype, bus.is_jump}), 112'({1'b1, 1'b0, 1'b0}));
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h0C100040, 1'b0, 1'b0, 1'b0);
        chk("jal", 112'({bus.is_jump, bus.address}), 112'({1'b1, 26'h0100040}));
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 120; i++) begin
            logic [31:0] w;
            w = $urandom;
            w[31:26] = ops[$urandom_range(9, 0)];
            cycle(1'($urandom_range(1, 0)), w, 1'($urandom_range(1, 0)),
                  1'($urandom_range(29, 0) == 0), 1'b0);
        end
        while (sb.size() != 0) cycle(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
